// File: rtl/serial_adder_pkg.sv
// arith_pkg: FSM state encodings and width limit shared by the serial adder files.
package arith_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// full_adder_bit: combinational 1-bit full adder cell.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial A+B+CIN, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_sr_q, sum_sr_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             s_bit, c_bit, load, shift, last;
  full_adder_bit u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (s_bit),
    .co  (c_bit)
  );
  always_comb begin
    load     = (state_q == ST_IDLE) && bus.start;
    shift    = (state_q == ST_SHIFT);
    last     = shift && (cnt_q == CW'(WIDTH - 1));
    state_d  = load ? ST_SHIFT : last ? ST_DONE : (state_q == ST_DONE) ? ST_IDLE : state_q;
    cnt_d    = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    a_d      = load ? bus.a : shift ? a_q >> 1 : a_q;
    b_d      = load ? bus.b : shift ? b_q >> 1 : b_q;
    carry_d  = load ? bus.cin : shift ? c_bit : carry_q;
    sum_sr_d = shift ? {s_bit, sum_sr_q[WIDTH-1:1]} : sum_sr_q;
    sum_d    = last ? sum_sr_d : sum_q;
    cout_d   = last ? c_bit : cout_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  // on the final bit carry_q is the carry into the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (last) ovf_q <= carry_q ^ c_bit;
  end
  assign bus.ovf = ovf_q;
`endif
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder with WIDTH=8.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int n, pulses, last_i;
  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s check did not hold", tag);
    end
  endtask
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask
  task automatic chk_result(input string tag, input logic [7:0] s, input logic co, input logic ov);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_sum"}, bus.sum, s);
    chk({tag, "_cout"}, bus.cout, co);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, bus.ovf, ov);
`endif
    tick();
    chk({tag, "_done_clr"}, bus.done, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_hold"}, bus.sum, s);
  endtask
  task automatic full_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] s, input logic co, input logic ov);
    launch(a, b, cin);
    chk({tag, "_busy"}, bus.busy, 1);
    wait_done(n);
    chk({tag, "_lat"}, n, 8);
    chk_result(tag, s, co, ov);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rel_busy", bus.busy, 0);
    chk("rel_done", bus.done, 0);
    full_op("op5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b1 == 1'b0, 1'b1);
    full_op("opff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    full_op("opffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    launch(8'h12, 8'h34, 1'b0);
    repeat (3) tick();
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.cin = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign_busy", bus.busy, 1);
    wait_done(n);
    chk("ign_lat", n, 4);
    chk_result("ign", 8'h46, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    chk("ign_no_requeue", pulses, 0);
    launch(8'h5A, 8'h33, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_sum", bus.sum, 0);
    chk("arst_cout", bus.cout, 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    chk("arst_no_done", pulses, 0);
    full_op("post_rst", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    bus.a = 8'h01;
    bus.b = 8'h02;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    pulses = 0;
    last_i = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        pulses++;
        if (pulses == 1) chk("held_first", i, 9);
        else chk("held_period", i - last_i, 10);
        last_i = i;
      end
      chk("held_sum", bus.sum, (i >= 9) ? 8'h03 : 8'h00);
    end
    bus.start = 1'b0;
    chk("held_pulses", pulses, 3);
    repeat (12) tick();
    chk("held_end_idle", bus.busy, 0);
    chk("held_end_sum", bus.sum, 8'h03);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
